spike_rate_decoder: RTL
=======================

Name: spike_rate_decoder

Overview:
Output-side reader for the SNN core. It consumes the output-layer spike vector once per timestep over a fixed window and counts spikes per output neuron. When the window ends, it scans the counts and reports the winning class (argmax of the spike rate) with a one-cycle done pulse. It sits between the SNN core's output spikes and the classification/result logic, and is armed by the same start_en that launches an inference.

Parameters:
N_OUT, 10, number of output neurons (classes); must be >= 2
T_STEPS, 16, number of accepted timesteps per inference window; must be >= 1
CNT_W, 8, per-neuron spike counter width; counters saturate at 2^CNT_W-1
CLS_W, $clog2(N_OUT), derived localparam; width of the class index

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start_en  input  1  arms a new window; sampled only in IDLE
spike_valid  input  1  spike_in holds one timestep's output spikes this cycle
spike_in  input  N_OUT  output-layer spike vector, bit i = neuron i fired
busy  output  1  high in ACCUM and SCAN
done  output  1  one-cycle pulse; class_out/max_count valid from this cycle on
class_out  output  CLS_W  index of the neuron with the highest spike count
max_count  output  CNT_W  spike count of the winning neuron

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- On reset: state=IDLE, all counters=0, step counter=0, scan index=0, busy=0, done=0, class_out=0, max_count=0. Reset has priority in any state, including mid-ACCUM and mid-SCAN. A partial result is discarded and done does not fire.
- FSM states: IDLE, ACCUM, SCAN, DONE.
- IDLE: spike_valid is ignored. start_en=1 clears all counters and the step counter, then moves to ACCUM. class_out and max_count hold their previous values.
- ACCUM: busy=1. Each cycle with spike_valid=1, for each i, counter[i] = counter[i] + spike_in[i], saturating at 2^CNT_W-1 with no wrap, and the step counter increments. Cycles with spike_valid=0 change nothing. The beat that brings the step counter to T_STEPS moves the FSM to SCAN. start_en is ignored.
- SCAN: busy=1. One neuron is evaluated per cycle, idx = 0..N_OUT-1. The running best starts at (index 0, count 0). An entry updates the running best only if counter[idx] > best count (strict comparison), so ties resolve to the lowest index. After idx=N_OUT-1 is evaluated, the FSM goes to DONE, and class_out/max_count are loaded from the running best on the same edge. spike_valid and start_en are ignored.
- DONE: one cycle with done=1 and busy=0, then IDLE. start_en is not honoured in DONE; it must be high in a later IDLE cycle.
- Latency: if the final valid beat is accepted on edge k, SCAN runs over edges k+1..k+N_OUT and done is high in the cycle following edge k+N_OUT.
- All-zero counts give class_out=0, max_count=0, and done still pulses.
- Back-to-back inference: start_en held high fires again in the IDLE cycle immediately after DONE.

Decomposition:
- Shared package snn_pkg: FSM state enum (IDLE/ACCUM/SCAN/DONE), default N_OUT/T_STEPS/CNT_W constants, and the class index type.
- Sub-module sat_counter: single CNT_W-bit counter with clear, increment enable and saturation, instantiated N_OUT times via generate.
- FSM, step counter and argmax scan stay in the top module.

Test Plan:
Params N_OUT=4, T_STEPS=4, CNT_W=3 unless noted.
- Basic: start_en, then 4 valid beats of spike_in=4'b0100 -> done 5 cycles after the last beat, class_out=2, max_count=4, busy high ACCUM..SCAN only.
- Tie and gaps: beats 0011, 0000, 0011, 0000 with spike_valid=0 idle cycles interleaved -> gaps not counted, class_out=0, max_count=2.
- Saturation: T_STEPS=10, spike_in=4'b1000 every beat -> counter[3] stops at 7, class_out=3, max_count=7.
- Ignored inputs: spike_valid=1 in IDLE before start, and start_en pulsed during ACCUM/SCAN -> no count change, no restart, single done.
- Reset mid-ACCUM after 2 beats -> all outputs 0, no done; a fresh start then 4 beats of 0001 -> class_out=0, max_count=4.
- Back-to-back: start_en held high through two windows (0010 then 1000) -> two done pulses, class_out 1 then 3, counters cleared between windows.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared FSM states, default sizing and class index type for the SNN output decoder
package snn_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
  localparam int N_OUT_DEF = 10;
  localparam int T_STEPS_DEF = 16;
  localparam int CNT_W_DEF = 8;
  typedef logic [$clog2(N_OUT_DEF)-1:0] cls_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts output spikes over a fixed window, then scans for the argmax class
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int T_STEPS = T_STEPS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int CLS_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_en,
  input  logic             spike_valid,
  input  logic [N_OUT-1:0] spike_in,
  output logic             busy,
  output logic             done,
  output logic [CLS_W-1:0] class_out,
  output logic [CNT_W-1:0] max_count
);
  localparam int SW = $clog2(T_STEPS + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(T_STEPS - 1);
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_OUT - 1);
  state_t state;
  logic [SW-1:0] stp;
  logic [CLS_W-1:0] idx, best_idx, nxt_idx;
  logic [CNT_W-1:0] best_cnt, nxt_cnt, cand;
  logic [CNT_W-1:0] counts [N_OUT];
  logic clr, upd;
  assign clr = state == IDLE && start_en;
  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk(clk),
      .reset(reset),
      .clr(clr),
      .inc(state == ACCUM && spike_valid && spike_in[g]),
      .q(counts[g])
    );
  end
  // strict compare keeps the earliest index on ties
  always_comb begin
    cand = counts[idx];
    upd = cand > best_cnt;
    nxt_idx = upd ? idx : best_idx;
    nxt_cnt = upd ? cand : best_cnt;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      stp <= '0;
      idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      class_out <= '0;
      max_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start_en) begin
          stp <= '0;
          busy <= 1'b1;
          state <= ACCUM;
        end
        ACCUM: if (spike_valid) begin
          stp <= stp + 1'b1;
          if (stp == LAST_STEP) begin
            idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          best_idx <= nxt_idx;
          best_cnt <= nxt_cnt;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            class_out <= nxt_idx;
            max_count <= nxt_cnt;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
